seg_scroll_feed: RTL and testbench

SEG_SCROLL_FEED -- requirements
Module: seg_scroll_feed

---
 rtl/seg_scroll_feed_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/seg_scroll_feed.sv | 135 +++++++++++++
 tb/tb_seg_scroll_feed.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scroll_feed_pkg.sv
// Shared definitions for the scrolling seven-segment message feed:
// glyph codes, FSM state encoding and scroll direction values.
package seg_scroll_feed_pkg;

    localparam logic [3:0] GLYPH_C     = 4'hA;
    localparam logic [3:0] GLYPH_S     = 4'hB;
    localparam logic [3:0] GLYPH_F     = 4'hC;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    localparam int MSG_GLYPHS = 16;
    localparam int WIN_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'd16) ? 5'd16 : len;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_pulse <= 1'b0;
            // Any agreement with the accepted level restarts the stability window.
            if (r_sync[1] != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync[1];
                    r_pulse <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule

// File: rtl/seg_scroll_feed.sv
// Scrolls a stored message of up to 16 glyphs through an 8-digit window,
// with debounced pause/run and direction buttons.
module seg_scroll_feed
    import seg_scroll_feed_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_load,
    input  logic [63:0] msg_data,
    input  logic [4:0]  msg_len,
    input  logic        btn_pause,
    input  logic        btn_dir,
    output logic [31:0] win_digits,
    output logic        win_valid,
    output logic [3:0]  scroll_pos,
    output logic        paused
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_dir;
    logic [TW-1:0] r_tick;
    logic [3:0]    r_pos;
    logic [4:0]    r_len;
    logic [63:0]   r_msg;
    logic [31:0]   r_win;
    logic          r_win_valid;

    logic        w_pause_pulse;
    logic        w_dir_pulse;
    logic        w_pause_level;
    logic        w_dir_level;
    logic        w_unused;
    logic        w_step;
    logic [4:0]  w_len_eff;
    logic [4:0]  w_pos_inc;
    logic [3:0]  w_pos_fwd;
    logic [3:0]  w_pos_back;
    logic [31:0] w_win;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_pause),
        .level   (w_pause_level),
        .pulse   (w_pause_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_dir),
        .level   (w_dir_level),
        .pulse   (w_dir_pulse)
    );

    assign w_unused  = &{1'b0, w_pause_level, w_dir_level};

    assign w_len_eff  = clamp_len(msg_len);
    assign w_step     = (r_state == ST_RUN) && (r_tick == TICK_LAST);
    assign w_pos_inc  = {1'b0, r_pos} + 5'd1;
    assign w_pos_fwd  = (w_pos_inc >= r_len) ? 4'd0 : w_pos_inc[3:0];
    assign w_pos_back = (r_pos == 4'd0) ? 4'(r_len - 5'd1) : r_pos - 4'd1;

    always_comb begin
        w_state_next = r_state;
        if (msg_load) begin
            w_state_next = (w_len_eff != 5'd0) ? ST_RUN : ST_IDLE;
        end else if (w_pause_pulse) begin
            case (r_state)
                ST_RUN:   w_state_next = ST_PAUSE;
                ST_PAUSE: w_state_next = ST_RUN;
                default:  w_state_next = r_state;
            endcase
        end
    end

    // Long messages wrap modulo len; short ones are shown left-aligned and blank-padded.
    for (genvar gi = 0; gi < WIN_DIGITS; gi++) begin : g_digit
        logic [4:0] w_sum;
        logic [3:0] w_idx;
        assign w_sum = {1'b0, r_pos} + 5'(gi);
        assign w_idx = (w_sum >= r_len) ? 4'(w_sum - r_len) : w_sum[3:0];
        assign w_win[4*gi +: 4] = (r_len > 5'd8)     ? r_msg[{w_idx, 2'b00} +: 4] :
                                  (5'(gi) < r_len)   ? r_msg[4*gi +: 4] :
                                                       GLYPH_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dir       <= DIR_LEFT;
            r_tick      <= '0;
            r_pos       <= 4'd0;
            r_len       <= 5'd0;
            r_msg       <= {MSG_GLYPHS{GLYPH_BLANK}};
            r_win       <= {WIN_DIGITS{GLYPH_BLANK}};
            r_win_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (msg_load) begin
                r_msg  <= msg_data;
                r_len  <= w_len_eff;
                r_pos  <= 4'd0;
                r_tick <= '0;
                r_dir  <= DIR_LEFT;
            end else begin
                if (w_dir_pulse) begin
                    r_dir <= ~r_dir;
                end
                if (r_state == ST_RUN) begin
                    r_tick <= w_step ? '0 : r_tick + TW'(1);
                end
                // r_dir is the pre-toggle value here, so a coincident dir press waits a step.
                if (w_step && (r_len > 5'd8)) begin
                    r_pos <= (r_dir == DIR_LEFT) ? w_pos_fwd : w_pos_back;
                end
            end
            r_win       <= (r_state == ST_IDLE) ? {WIN_DIGITS{GLYPH_BLANK}} : w_win;
            r_win_valid <= (r_state != ST_IDLE);
        end
    end

    assign win_digits = r_win;
    assign win_valid  = r_win_valid;
    assign scroll_pos = r_pos;
    assign paused     = (r_state == ST_PAUSE);

endmodule

// File: tb/tb_seg_scroll_feed.sv
// Directed bench for seg_scroll_feed with TICK_DIV=4, DEB_CYCLES=3; all
// expected values are hand-derived cycle positions and window contents.
module tb_seg_scroll_feed;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_load;
    logic [63:0] msg_data;
    logic [4:0]  msg_len;
    logic        btn_pause;
    logic        btn_dir;
    logic [31:0] win_digits;
    logic        win_valid;
    logic [3:0]  scroll_pos;
    logic        paused;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] MSG_2021F = 64'hFFFF_FFFF_FFFF_1202;
    localparam logic [63:0] MSG_TEN   = 64'hFFFF_FF98_7654_3210;
    localparam logic [63:0] MSG_HEX   = 64'hFEDC_BA98_7654_3210;
    localparam logic [31:0] WIN_BLANK = 32'hFFFF_FFFF;

    seg_scroll_feed #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_load   (msg_load),
        .msg_data   (msg_data),
        .msg_len    (msg_len),
        .btn_pause  (btn_pause),
        .btn_dir    (btn_dir),
        .win_digits (win_digits),
        .win_valid  (win_valid),
        .scroll_pos (scroll_pos),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [63:0] d, input logic [4:0] l);
        msg_data = d;
        msg_len  = l;
        msg_load = 1'b1;
        cyc(1);
        msg_load = 1'b0;
        $display("load len=%0d data=%h", l, d);
    endtask

    task automatic press_pause(input int n);
        btn_pause = 1'b1;
        cyc(n);
        btn_pause = 1'b0;
    endtask

    function automatic logic [31:0] pos32(input logic [3:0] p);
        return {28'd0, p};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; msg_load = 1'b0; msg_data = '0; msg_len = '0;
        btn_pause = 1'b0; btn_dir = 1'b0;
        cyc(3);
        chk("rst_win",    win_digits, WIN_BLANK);
        chk("rst_valid",  {31'd0, win_valid}, 32'd0);
        chk("rst_pos",    pos32(scroll_pos), 32'd0);
        chk("rst_paused", {31'd0, paused}, 32'd0);
        rst = 1'b0;
        cyc(2);
        chk("idle_valid", {31'd0, win_valid}, 32'd0);

        // short message: static, blank-padded
        load(MSG_2021F, 5'd5);
        cyc(1);
        chk("short_win",   win_digits, 32'hFFFF_1202);
        chk("short_valid", {31'd0, win_valid}, 32'd1);
        cyc(40);
        chk("short_pos",   pos32(scroll_pos), 32'd0);
        chk("short_win2",  win_digits, 32'hFFFF_1202);

        // len=10 scroll left
        load(MSG_TEN, 5'd10);
        cyc(4);
        chk("ten_pos1",  pos32(scroll_pos), 32'd1);
        cyc(1);
        chk("ten_win1",  win_digits, 32'h8765_4321);
        cyc(39);
        chk("ten_wrap",  pos32(scroll_pos), 32'd1);

        // direction press timed so its pulse lands just after the load
        btn_dir = 1'b1;
        cyc(3);
        load(MSG_TEN, 5'd10);
        cyc(2);
        btn_dir = 1'b0;
        cyc(2);
        chk("dir_pos9", pos32(scroll_pos), 32'd9);
        cyc(1);
        chk("dir_win",  win_digits, 32'h6543_2109);
        cyc(3);
        chk("dir_pos8", pos32(scroll_pos), 32'd8);

        // pause: glitch ignored, full press pauses, second press resumes count
        load(MSG_TEN, 5'd10);
        press_pause(2);
        cyc(8);
        chk("glitch_paused", {31'd0, paused}, 32'd0);
        load(MSG_TEN, 5'd10);
        press_pause(6);
        chk("pause_on",   {31'd0, paused}, 32'd1);
        chk("pause_pos",  pos32(scroll_pos), 32'd1);
        cyc(10);
        chk("pause_hold", pos32(scroll_pos), 32'd1);
        chk("pause_on2",  {31'd0, paused}, 32'd1);
        press_pause(6);
        chk("resume",     {31'd0, paused}, 32'd0);
        cyc(1);
        chk("resume_pos1", pos32(scroll_pos), 32'd1);
        cyc(1);
        chk("resume_pos2", pos32(scroll_pos), 32'd2);

        // load coincident with a step
        load(MSG_TEN, 5'd10);
        cyc(7);
        chk("coin_pre",  pos32(scroll_pos), 32'd1);
        load(MSG_TEN, 5'd10);
        chk("coin_pos",  pos32(scroll_pos), 32'd0);
        cyc(3);
        chk("coin_hold", pos32(scroll_pos), 32'd0);
        cyc(1);
        chk("coin_step", pos32(scroll_pos), 32'd1);

        // asynchronous reset mid-run
        #2;
        rst = 1'b1;
        #1;
        chk("arst_win",    win_digits, WIN_BLANK);
        chk("arst_valid",  {31'd0, win_valid}, 32'd0);
        chk("arst_pos",    pos32(scroll_pos), 32'd0);
        chk("arst_paused", {31'd0, paused}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(20);
        chk("post_rst_valid", {31'd0, win_valid}, 32'd0);
        chk("post_rst_win",   win_digits, WIN_BLANK);

        // len clamped to 16, wrap 15 -> 0
        load(MSG_HEX, 5'd20);
        cyc(60);
        chk("clamp_pos15", pos32(scroll_pos), 32'd15);
        cyc(1);
        chk("clamp_win",   win_digits, 32'h6543_210F);
        cyc(3);
        chk("clamp_wrap",  pos32(scroll_pos), 32'd0);

        // len=0 returns to IDLE; pause press ignored there
        load(MSG_HEX, 5'd0);
        cyc(1);
        chk("len0_valid", {31'd0, win_valid}, 32'd0);
        chk("len0_win",   win_digits, WIN_BLANK);
        press_pause(6);
        cyc(8);
        chk("idle_pause", {31'd0, paused}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
